// File: rtl/piso_serializer_p8_if.sv
// Handshake and serial-stream bundle for piso_serializer_p8.
// The master modport is the word source and serial sink; the slave modport is the serializer.
interface piso_serializer_p8_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             done;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  ser_out,
        input  ser_valid,
        input  done
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output ser_out,
        output ser_valid,
        output done
    );
endinterface

// File: rtl/piso_serializer_p8.sv
// Parallel-in/serial-out transmitter: accepts one word and shifts it out MSB first.
// Define PARITY_EN to append one even-parity bit to every frame.
module piso_serializer_p8 #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    piso_serializer_p8_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

`ifdef PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic             ser_out_q, ser_out_n;
    logic             ser_valid_q, ser_valid_n;
    logic             done_q, done_n;
`ifdef PARITY_EN
    // The shift register is consumed while shifting, so parity is captured at accept.
    logic             parity, parity_n;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            shreg       <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef PARITY_EN
            parity      <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            shreg       <= shreg_n;
            ser_out_q   <= ser_out_n;
            ser_valid_q <= ser_valid_n;
            done_q      <= done_n;
`ifdef PARITY_EN
            parity      <= parity_n;
`endif
        end
    end

    // Serial outputs are computed one cycle ahead so that they leave the block straight from flops.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        shreg_n     = shreg;
        ser_out_n   = 1'b0;
        ser_valid_n = 1'b0;
        done_n      = 1'b0;
`ifdef PARITY_EN
        parity_n    = parity;
`endif
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    shreg_n     = bus.in_data;
                    cnt_n       = '0;
                    state_n     = SHIFT;
                    ser_out_n   = bus.in_data[WIDTH-1];
                    ser_valid_n = 1'b1;
`ifdef PARITY_EN
                    parity_n    = ^bus.in_data;
`endif
                end
            end
            SHIFT: begin
                shreg_n = {shreg[WIDTH-2:0], 1'b0};
                cnt_n   = cnt + CNT_W'(1);
                if (cnt == LAST) begin
                    cnt_n = '0;
`ifdef PARITY_EN
                    state_n     = PARITY;
                    ser_out_n   = parity;
                    ser_valid_n = 1'b1;
`else
                    state_n = IDLE;
                    done_n  = 1'b1;
`endif
                end else begin
                    ser_out_n   = shreg_n[WIDTH-1];
                    ser_valid_n = 1'b1;
                end
            end
`ifdef PARITY_EN
            PARITY: begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
`endif
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.ser_out   = ser_out_q;
    assign bus.ser_valid = ser_valid_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_piso_serializer_p8.sv
// Scoreboard bench for piso_serializer_p8: accepted words are queued with their accept edge,
// and a negedge monitor predicts every output from the word and the elapsed cycle count.
module tb_piso_serializer_p8;
    localparam int WIDTH = 8;
`ifdef PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    logic clk = 1'b0;
    logic rst;

    piso_serializer_p8_if #(.WIDTH(WIDTH)) bus ();

    piso_serializer_p8 #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] word;
        int               acc;
    } frame_t;

    frame_t sb[$];
    int     cyc    = 0;
    int     total  = 0;
    int     bad    = 0;
    int     runLen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame position k carries word bit WIDTH-1-k; the optional final position carries even parity.
    function automatic logic expBit(input logic [WIDTH-1:0] w, input int k);
        if (k < WIDTH) return w[WIDTH-1-k];
        return ^w;
    endfunction

    task automatic compare(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    task automatic checkOutput();
        frame_t f;
        logic   haveF;
        int     rel;
        logic   expValid;
        logic   expDone;
        rel   = 0;
        haveF = (sb.size() > 0) && (sb[0].acc <= cyc);
        if (haveF) begin
            f   = sb[0];
            rel = cyc - f.acc;
        end
        compare("in_ready", 32'(bus.in_ready), 32'(!rst && (!haveF || rel >= FRAME)));
        expValid = haveF && (rel < FRAME);
        expDone  = haveF && (rel == FRAME);
        compare("ser_valid", 32'(bus.ser_valid), 32'(expValid));
        if (expValid)
            compare("ser_out bit", 32'(bus.ser_out), 32'(expBit(f.word, rel)));
        else
            compare("ser_out idle", 32'(bus.ser_out), 32'(0));
        compare("done", 32'(bus.done), 32'(expDone));
        if (expDone) void'(sb.pop_front());
        if (bus.ser_valid) begin
            runLen++;
            compare("valid run length", 32'(runLen <= FRAME), 32'(1));
        end else begin
            runLen = 0;
        end
    endtask

    always @(negedge clk) checkOutput();

    // Entered just after a rising edge; returns just after the edge that accepted the word.
    task automatic applyStimulus(input logic [WIDTH-1:0] w, input int gap);
        int waited;
        for (int g = 0; g < gap; g++) begin
            bus.in_valid = 1'b0;
            bus.in_data  = WIDTH'($urandom);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        waited = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back('{word: w, acc: cyc + 1});
                @(posedge clk);
                #1;
                break;
            end
            waited++;
            if (waited > 4 * FRAME) begin
                total++;
                bad++;
                $display("[TB] FAIL accept timeout for word %0h: got no in_ready expected in_ready within %0d cycles", w, 4 * FRAME);
                bus.in_valid = 1'b0;
                @(posedge clk);
                #1;
                break;
            end
        end
    endtask

    // Any frame in flight is dropped from the scoreboard once the reset edge has been taken.
    task automatic applyReset(input int cycles);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = WIDTH'($urandom);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            sb.delete();
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        applyReset(2);
        @(posedge clk);
        #1;

        applyStimulus(8'hA5, 1);
        applyStimulus(8'h07, 2);
        applyStimulus(8'h3C, 1);
        applyStimulus(8'hFF, 0);
        applyStimulus(8'h81, 2);
        applyStimulus(8'h7E, 0);

        applyStimulus(8'hF0, 1);
        repeat (3) @(posedge clk);
        #1;
        applyReset(1);
        applyStimulus(8'h55, 1);

        for (int i = 0; i < 40; i++)
            applyStimulus(WIDTH'($urandom), int'($urandom_range(0, 3)));

        bus.in_valid = 1'b0;
        repeat (FRAME + 3) @(posedge clk);
        #1;
        compare("scoreboard drained", 32'(sb.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
